// File: rtl/axi_wr_burst_scheduler.sv
// axi_wr_burst_scheduler: splits a frame descriptor into AXI INCR write bursts and
// hands each one to the write core once the data FIFO holds the whole burst.
// Optional feature: define AXI_WR_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module axi_wr_burst_scheduler #(
  parameter int unsigned LSIZE          = 10,
  parameter int unsigned ASIZE          = 32,
  parameter int unsigned TSIZE          = 24,
  parameter int unsigned CSIZE          = 12,
  parameter int unsigned MAX_BURST      = 256,
  parameter int unsigned BYTES_PER_BEAT = 32,
  parameter int unsigned TIMEOUT_W      = 24
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             frame_start,
  input  logic [ASIZE-1:0] frame_base,
  input  logic [TSIZE-1:0] frame_beats,
  input  logic [CSIZE-1:0] fifo_count,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [TSIZE-1:0] beats_left,
  output logic             write_req,
  output logic [LSIZE-1:0] req_len,
  output logic [ASIZE-1:0] req_addr,
  input  logic             req_resp,
  input  logic             req_done
);

  localparam int unsigned OFFS = $clog2(BYTES_PER_BEAT);
  localparam logic [ASIZE-1:0] AddrMask = ASIZE'(BYTES_PER_BEAT - 1);

  typedef enum logic [2:0] {
    StIdle, StCalc, StWaitData, StReq, StWaitDone, StDone, StErr
  } state_e;

  state_e               state_q, state_d;
  logic [ASIZE-1:0]     cur_addr_q, cur_addr_d;
  logic [LSIZE-1:0]     blen_q, blen_d;
  logic [TSIZE-1:0]     beats_left_q, beats_left_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 write_req_q, write_req_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [TSIZE-1:0]     blen_lim;

  // Length of the next burst: remaining beats capped by MAX_BURST (and the 4 KB page).
`ifdef AXI_WR_4K_SPLIT_EN
  logic [12:0] room_bytes;
  logic [12:0] room_beats;
  always_comb begin
    room_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
    room_beats = room_bytes >> OFFS;
    blen_lim   = (beats_left_q < TSIZE'(MAX_BURST)) ? beats_left_q : TSIZE'(MAX_BURST);
    if (TSIZE'(room_beats) < blen_lim) blen_lim = TSIZE'(room_beats);
  end
`else
  always_comb begin
    blen_lim = (beats_left_q < TSIZE'(MAX_BURST)) ? beats_left_q : TSIZE'(MAX_BURST);
  end
`endif

  // Next-state, datapath updates and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    blen_d       = blen_q;
    beats_left_d = beats_left_q;
    wd_d         = wd_q;
    wd_inc       = wd_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          cur_addr_d   = frame_base & ~AddrMask;
          beats_left_d = frame_beats;
          state_d      = (frame_beats == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        blen_d  = LSIZE'(blen_lim);
        state_d = StWaitData;
      end
      StWaitData: begin
        if (32'(fifo_count) >= 32'(blen_q)) state_d = StReq;
      end
      StReq: begin
        if (req_resp) begin
          wd_d    = '0;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (req_done) begin
          cur_addr_d   = cur_addr_q + (ASIZE'(blen_q) << OFFS);
          beats_left_d = beats_left_q - TSIZE'(blen_q);
          state_d      = (beats_left_q == TSIZE'(blen_q)) ? StDone : StCalc;
        end else begin
          wd_d = wd_inc;
          // Leave after 2^TIMEOUT_W - 1 cycles without a response.
          if (&wd_inc) state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    write_req_d = (state_d == StReq);
    busy_d      = (state_d != StIdle);
    // done follows the DONE state by one cycle; err is raised while ERR is occupied.
    done_d      = (state_q == StDone);
    err_d       = (state_d == StErr);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q      <= StIdle;
      cur_addr_q   <= '0;
      blen_q       <= '0;
      beats_left_q <= '0;
      wd_q         <= '0;
      write_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      blen_q       <= blen_d;
      beats_left_q <= beats_left_d;
      wd_q         <= wd_d;
      write_req_q  <= write_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign beats_left = beats_left_q;
  assign write_req  = write_req_q;
  assign req_len    = blen_q;
  assign req_addr   = cur_addr_q;

endmodule
